// File: rtl/rx_input_fifo_if.sv
// Handshake bundle between an Aurora RX lane, the per-port input FIFO and the data controller.
// The drop_count member exists only when RX_FIFO_DROP_CNT_EN is defined.
interface rx_input_fifo_if #(
  parameter int AURORA_DATA_WIDTH = 256,
  parameter int ADDR_WIDTH        = 10
);
  logic                         rx_tvalid;
  logic [AURORA_DATA_WIDTH-1:0] rx_tdata;
  logic                         rd;
  logic [AURORA_DATA_WIDTH-1:0] rd_data;
  logic                         empty;
  logic                         full;
  logic                         almost_full;
  logic [ADDR_WIDTH:0]          count;
  logic                         overflow;
`ifdef RX_FIFO_DROP_CNT_EN
  logic [15:0]                  drop_count;
`endif

  // master: Aurora source plus data controller; slave: the FIFO itself
  modport master (
    output rx_tvalid, rx_tdata, rd,
    input  rd_data, empty, full, almost_full, count, overflow
`ifdef RX_FIFO_DROP_CNT_EN
    , input drop_count
`endif
  );

  modport slave (
    input  rx_tvalid, rx_tdata, rd,
    output rd_data, empty, full, almost_full, count, overflow
`ifdef RX_FIFO_DROP_CNT_EN
    , output drop_count
`endif
  );
endinterface

// File: rtl/rx_input_fifo.sv
// Per-port receive FIFO: Aurora RX words in without backpressure, registered reads out to the controller.
// Optional saturating dropped-word counter enabled by defining RX_FIFO_DROP_CNT_EN.
module rx_input_fifo #(
  parameter int AURORA_DATA_WIDTH  = 256,
  parameter int ADDR_WIDTH         = 10,
  parameter int ALMOST_FULL_THRESH = 1016
) (
  input logic           clk,
  input logic           rst_n,
  rx_input_fifo_if.slave fifo_if
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [AURORA_DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]          wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]          rd_ptr_q, rd_ptr_d;
  logic [AURORA_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                         overflow_q, overflow_d;
  logic [ADDR_WIDTH:0]          count;
  logic                         empty, full, rd_en, wr_en, drop;

  // Extra wrap bit distinguishes full from empty when the addresses match
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    rd_en      = fifo_if.rd && !empty;
    wr_en      = fifo_if.rx_tvalid && (!full || rd_en);
    drop       = fifo_if.rx_tvalid && full && !rd_en;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q || drop;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  // When full, a same-cycle write lands on the slot being read; the read sees the old word
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo_if.rx_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef RX_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign fifo_if.drop_count = drop_cnt_q;
`endif

  assign fifo_if.rd_data     = rd_data_q;
  assign fifo_if.empty       = empty;
  assign fifo_if.full        = full;
  assign fifo_if.almost_full = (int'(count) >= ALMOST_FULL_THRESH);
  assign fifo_if.count       = count;
  assign fifo_if.overflow    = overflow_q;
endmodule

// File: tb/tb_rx_input_fifo.sv
// Randomised self-checking bench for rx_input_fifo: a queue-based model is compared every cycle,
// with literal expectations at key points. Checks drop_count when RX_FIFO_DROP_CNT_EN is defined.
module tb_rx_input_fifo;
  localparam int W      = 256;
  localparam int A      = 10;
  localparam int DEPTH  = 1 << A;
  localparam int THRESH = 1016;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  rx_input_fifo_if #(.AURORA_DATA_WIDTH(W), .ADDR_WIDTH(A)) fif ();

  rx_input_fifo #(
    .AURORA_DATA_WIDTH (W),
    .ADDR_WIDTH        (A),
    .ALMOST_FULL_THRESH(THRESH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .fifo_if(fif)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus the last word handed out and the sticky error state
  logic [W-1:0] mq [$];
  logic [W-1:0] m_rd_data = '0;
  logic         m_overflow = 1'b0;
  int           m_drops = 0;
  logic         model_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_rd_data   = '0;
      m_overflow  = 1'b0;
      m_drops     = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      bit was_full, rd_ok, wr_ok;
      was_full = (mq.size() >= DEPTH);
      rd_ok    = fif.rd && (mq.size() != 0);
      wr_ok    = fif.rx_tvalid && (!was_full || rd_ok);
      if (rd_ok) m_rd_data = mq.pop_front();
      if (wr_ok) mq.push_back(fif.rx_tdata);
      if (fif.rx_tvalid && !wr_ok) begin
        m_overflow = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (model_valid && rst_n) begin
      checkOutput("empty",       fif.empty,       mq.size() == 0);
      checkOutput("full",        fif.full,        mq.size() == DEPTH);
      checkOutput("almost_full", fif.almost_full, mq.size() >= THRESH);
      checkOutput("count",       fif.count,       mq.size());
      checkOutput("rd_data",     fif.rd_data,     m_rd_data);
      checkOutput("overflow",    fif.overflow,    m_overflow);
`ifdef RX_FIFO_DROP_CNT_EN
      checkOutput("drop_count",  fif.drop_count,  m_drops);
`endif
    end
  end

  task automatic applyStimulus(input logic tvalid, input logic [W-1:0] data, input logic rd);
    fif.rx_tvalid = tvalid;
    fif.rx_tdata  = data;
    fif.rd        = rd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] randWord();
    logic [W-1:0] w;
    for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  initial begin
    logic [W-1:0] last_word;
    fif.rx_tvalid = 1'b0;
    fif.rx_tdata  = '0;
    fif.rd        = 1'b0;

    // Reset then idle reads
    rst_n = 1'b0;
    applyStimulus(0, '0, 0);
    applyStimulus(0, '0, 0);
    rst_n = 1'b1;
    checkOutput("reset_empty",   fif.empty,   1);
    checkOutput("reset_full",    fif.full,    0);
    checkOutput("reset_count",   fif.count,   0);
    checkOutput("reset_rd_data", fif.rd_data, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1);
    checkOutput("idle_rd_data", fif.rd_data, 0);
    checkOutput("idle_count",   fif.count,   0);

    // Five words in, five out
    for (int i = 1; i <= 5; i++) applyStimulus(1, W'(i), 0);
    checkOutput("five_count", fif.count, 5);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, '0, 1);
      checkOutput("five_rd_data", fif.rd_data, W'(i));
    end
    checkOutput("five_empty", fif.empty, 1);

    // Fill to capacity, then overflow with three more words
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, randWord(), 0);
      if (i == THRESH - 2) checkOutput("af_below", fif.almost_full, 0);
      if (i == THRESH - 1) checkOutput("af_at",    fif.almost_full, 1);
      if (i == DEPTH - 2)  checkOutput("full_below", fif.full, 0);
    end
    checkOutput("fill_full",  fif.full,  1);
    checkOutput("fill_count", fif.count, DEPTH);
    checkOutput("pre_ovf",    fif.overflow, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, randWord(), 0);
    checkOutput("ovf_set",   fif.overflow, 1);
    checkOutput("ovf_count", fif.count,    DEPTH);
`ifdef RX_FIFO_DROP_CNT_EN
    checkOutput("drop_three", fif.drop_count, 3);
`endif

    // Full with simultaneous read and write: no drop, new word comes out last
    applyStimulus(1, W'(32'hABCD), 1);
    checkOutput("fullrw_count", fif.count, DEPTH);
`ifdef RX_FIFO_DROP_CNT_EN
    checkOutput("fullrw_drops", fif.drop_count, 3);
`endif
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, '0, 1);
    checkOutput("drain_last",  fif.rd_data, W'(32'hABCD));
    checkOutput("drain_empty", fif.empty,   1);

    // Streaming: one in, one out per cycle across several pointer wraps
    last_word = randWord();
    applyStimulus(1, last_word, 0);
    for (int i = 1; i < 3000; i++) begin
      last_word = randWord();
      applyStimulus(1, last_word, 1);
      if (fif.count > 1) checkOutput("stream_count_le1", fif.count, 1);
    end
    applyStimulus(0, '0, 1);
    checkOutput("stream_last",  fif.rd_data, last_word);
    checkOutput("stream_empty", fif.empty,   1);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      applyStimulus($urandom_range(0, 3) != 0, randWord(), $urandom_range(0, 1) == 1);

    // Drain, load 500 words, then reset mid-operation
    for (int i = 0; i < DEPTH + 4 && mq.size() > 0; i++) applyStimulus(0, '0, 1);
    for (int i = 0; i < 500; i++) applyStimulus(1, randWord(), 0);
    checkOutput("pre_rst_count", fif.count, 500);
    rst_n = 1'b0;
    applyStimulus(0, '0, 0);
    rst_n = 1'b1;
    checkOutput("rst_empty",    fif.empty,    1);
    checkOutput("rst_count",    fif.count,    0);
    checkOutput("rst_overflow", fif.overflow, 0);
    checkOutput("rst_rd_data",  fif.rd_data,  0);
    applyStimulus(1, W'(32'h77), 0);
    applyStimulus(0, '0, 1);
    checkOutput("post_rst_data",  fif.rd_data, W'(32'h77));
    checkOutput("post_rst_empty", fif.empty,   1);
    applyStimulus(0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_input_fifo.md
# rx_input_fifo

Per-port receive buffer between an Aurora lane's RX user interface and the router's data controller. Accepts one AURORA_DATA_WIDTH-bit word per cycle with no backpressure and stores it in a circular buffer of 2^ADDR_WIDTH entries. Presents an empty flag plus read-strobe/registered-data interface to the controller. One instance per input port (port 0 and port 1).

## Interface
- AURORA_DATA_WIDTH, 256, word width
- ADDR_WIDTH, 10, log2 of depth (depth = 1024)
- ALMOST_FULL_THRESH, 1016, occupancy at or above which almost_full asserts; legal range 1..2^ADDR_WIDTH

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- rx_tvalid  in  1  Aurora RX word valid; no ready returned
- rx_tdata  in  AURORA_DATA_WIDTH  Aurora RX word
- rd  in  1  read strobe from data controller
- rd_data  out  AURORA_DATA_WIDTH  registered read data
- empty  out  1  no stored words
- full  out  1  occupancy == 2^ADDR_WIDTH
- almost_full  out  1  occupancy >= ALMOST_FULL_THRESH
- count  out  ADDR_WIDTH+1  current occupancy
- overflow  out  1  sticky: a word was dropped since reset
- drop_count  out  16  dropped-word counter (present only with RX_FIFO_DROP_CNT_EN)

## Operation
- Storage: 2^ADDR_WIDTH x AURORA_DATA_WIDTH array, not reset.
- Pointers wr_ptr, rd_ptr: ADDR_WIDTH+1 bits (extra wrap bit). Address = low ADDR_WIDTH bits; increment modulo 2^(ADDR_WIDTH+1), natural wrap.
- empty = (wr_ptr == rd_ptr); full = address bits equal and wrap bits differ; count = wr_ptr - rd_ptr, ADDR_WIDTH+1 bits.
- Write accepted when rx_tvalid=1 and (full=0 or read accepted same cycle): store at wr_ptr, wr_ptr+1.
- rx_tvalid=1 while full and no accepted read: word dropped, pointers unchanged, overflow set to 1 (stays until reset).
- Read accepted when rd=1 and empty=0: rd_data <= mem[rd_ptr], rd_ptr+1.
- rd=1 while empty=1: ignored; rd_ptr and rd_data unchanged; no error flag.
- Simultaneous accepted read and write: both occur; count unchanged.
- Write and read same cycle while empty: write accepted, read ignored (empty was 1).
- Write and read same cycle while full: both accepted; no drop.
- Status flags are derived from registered pointers; they reflect the previous edge's updates.

## Timing
- Reset (rst_n=0 at rising edge): wr_ptr=rd_ptr=0, rd_data=0, empty=1, full=0, almost_full=0 (unless threshold 0, illegal), count=0, overflow=0, drop_count=0. Reset mid-operation discards all contents; next cycle behaves as freshly reset.
- Write latency: word written at edge N -> empty=0 and count updated after edge N; a rd at the following edge returns that word.
- Read latency: rd sampled high at edge N with empty=0 -> rd_data valid after edge N, held until next accepted read. Matches the controller, which strobes rd in its read state and samples data in the following state.
- Sustained throughput: one write and one read per cycle.
- Ordering strictly FIFO; no word duplicated or reordered across pointer wrap.

## Configuration
- RX_FIFO_DROP_CNT_EN defined: drop_count port present; increments by 1 on each dropped word, saturates at 16'hFFFF, cleared only by reset.
- Not defined: drop_count port and its counter absent; overflow sticky flag still present and unchanged in behaviour.

## Test plan
- Reset then idle: empty=1, full=0, count=0, rd_data=0; rd=1 for 5 cycles -> rd_data stays 0, count stays 0.
- Write 0x01..0x05 on consecutive cycles, then rd for 5 cycles -> rd_data 0x01..0x05 each one cycle after its rd; empty=1 after the last read.
- Fill to 1024 with no reads -> almost_full rises at count 1016, full=1 at 1024; 3 more writes -> dropped, overflow=1, drop_count=3 (macro on), contents intact on drain.
- Full plus simultaneous rd and rx_tvalid -> count stays 1024, no drop, new word read out last.
- Stream 3000 words with rd asserted every cycle after first write -> all 3000 read in order across pointer wrap, count never exceeds 1.
- rst_n low for one cycle with count=500 -> empty=1, count=0, overflow=0 next cycle; next write/read returns new data only.
